// File: rtl/key_conditioner_pkg.sv
// Shared constants and helpers for the key conditioner.
//   KC_N             default channel count
//   KC_TICK_DIV      default clk cycles per debounce sample tick
//   KC_STABLE_TICKS  default ticks a new level must persist to be accepted
//   cnt_width()      counter width for a 0..range_v-1 counter (at least 1 bit)
package key_cond_pkg;

  localparam int unsigned KC_N            = 21;
  localparam int unsigned KC_TICK_DIV     = 100000;
  localparam int unsigned KC_STABLE_TICKS = 10;

  function automatic int unsigned cnt_width(input int unsigned range_v);
    return (range_v <= 32'd1) ? 32'd1 : 32'($clog2(range_v));
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Board-pin side bundle of the key conditioner.
//   raw      unsynchronized pin inputs, active-high
//   mask     1 = suppress rise/fall for that channel
//   level    debounced level
//   rise     one-clk pulse on accepted 0->1
//   fall     one-clk pulse on accepted 1->0
//   any_rise OR of rise
// master drives raw/mask (board/bench side), slave is the conditioner.
interface key_conditioner_if
  import key_cond_pkg::*;
#(
  parameter int unsigned N = KC_N
) ();

  logic [N-1:0] raw;
  logic [N-1:0] mask;
  logic [N-1:0] level;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         any_rise;

  modport master (
    output raw, mask,
    input  level, rise, fall, any_rise
  );

  modport slave (
    input  raw, mask,
    output level, rise, fall, any_rise
  );

endinterface

// File: rtl/key_conditioner_chan.sv
// One conditioner channel: 2-FF synchronizer, tick-qualified debounce, edge detector.
//   clk, rstn  clock, async active-low reset
//   tick       shared debounce sample strobe
//   raw        unsynchronized pin
//   mask       suppresses rise/fall (level still tracked)
//   level      debounced level
//   rise/fall  one-cycle pulses on accepted transitions
module key_chan
  import key_cond_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = KC_STABLE_TICKS
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  input  logic raw,
  input  logic mask,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 32'd1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;

  // Synchronizer, debounce counter and edge-history register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_s1       <= raw;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      // Any sample agreeing with the accepted level restarts the count.
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (tick && (r_cnt == CNT_LAST)) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else if (tick) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Mask acts combinationally so a pulse masked in its cycle is dropped.
  assign level = r_stable;
  assign rise  = r_stable & ~r_stable_d & ~mask;
  assign fall  = ~r_stable & r_stable_d & ~mask;

endmodule

// File: rtl/key_conditioner.sv
// Conditions N raw board inputs into debounced levels and rise/fall pulses.
//   clk, rstn  clock, async active-low reset
//   bus        key_conditioner_if.slave: raw/mask in, level/rise/fall/any_rise out
// A free-running prescaler produces the shared debounce tick.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned N            = KC_N,
  parameter int unsigned TICK_DIV     = KC_TICK_DIV,
  parameter int unsigned STABLE_TICKS = KC_STABLE_TICKS
) (
  input  logic              clk,
  input  logic              rstn,
  key_conditioner_if.slave  bus
);

  localparam int unsigned PRE_W = cnt_width(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 32'd1);

  logic [PRE_W-1:0] r_pre;
  logic             w_tick;
  logic [N-1:0]     w_level;
  logic [N-1:0]     w_rise;
  logic [N-1:0]     w_fall;

  // Prescaler free-runs 0..TICK_DIV-1; never cleared by channel activity.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre <= '0;
    end else if (r_pre == PRE_LAST) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign w_tick = (r_pre == PRE_LAST);

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    key_chan #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_chan (
      .clk   (clk),
      .rstn  (rstn),
      .tick  (w_tick),
      .raw   (bus.raw[gi]),
      .mask  (bus.mask[gi]),
      .level (w_level[gi]),
      .rise  (w_rise[gi]),
      .fall  (w_fall[gi])
    );
  end

  assign bus.level    = w_level;
  assign bus.rise     = w_rise;
  assign bus.fall     = w_fall;
  assign bus.any_rise = |w_rise;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench: config A (N=4, TICK_DIV=1, STABLE_TICKS=4) and config B (N=4, TICK_DIV=3,
// STABLE_TICKS=2) share clk/rstn. Inputs change on negedge, outputs checked on negedge.
module tb_key_conditioner;

  logic clk;
  logic rstn;

  key_conditioner_if #(.N(4)) bus_a ();
  key_conditioner_if #(.N(4)) bus_b ();

  key_conditioner #(.N(4), .TICK_DIV(1), .STABLE_TICKS(4)) u_dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_a)
  );

  key_conditioner #(.N(4), .TICK_DIV(3), .STABLE_TICKS(2)) u_dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: per config, two-stage sample delay, accepted level and the
  // number of ticks the delayed sample has continuously disagreed with it.
  logic [3:0] m_s1  [2];
  logic [3:0] m_s2  [2];
  logic [3:0] m_lvl [2];
  logic [3:0] m_lvl_d [2];
  int         m_run [2][4];
  int         m_ph  [2];

  function automatic int td(input int c);
    return (c == 0) ? 1 : 3;
  endfunction

  function automatic int st(input int c);
    return (c == 0) ? 4 : 2;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 4'h0; m_s2[c] = 4'h0; m_lvl[c] = 4'h0; m_lvl_d[c] = 4'h0; m_ph[c] = 0;
      for (int i = 0; i < 4; i++) m_run[c][i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] raw_v;
    bit tk;
    for (int c = 0; c < 2; c++) begin
      raw_v = (c == 0) ? bus_a.raw : bus_b.raw;
      tk = (m_ph[c] == td(c) - 1);
      m_ph[c] = (m_ph[c] + 1) % td(c);
      m_lvl_d[c] = m_lvl[c];
      for (int i = 0; i < 4; i++) begin
        if (m_s2[c][i] == m_lvl[c][i]) begin
          m_run[c][i] = 0;
        end else if (tk) begin
          m_run[c][i] = m_run[c][i] + 1;
          if (m_run[c][i] == st(c)) begin
            m_lvl[c][i] = m_s2[c][i];
            m_run[c][i] = 0;
          end
        end
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = raw_v;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Compare both DUTs against the model (and B's tick against the model's phase).
  task automatic check_all();
    logic [3:0] er_a, ef_a, er_b, ef_b;
    er_a = m_lvl[0] & ~m_lvl_d[0] & ~bus_a.mask;
    ef_a = ~m_lvl[0] & m_lvl_d[0] & ~bus_a.mask;
    er_b = m_lvl[1] & ~m_lvl_d[1] & ~bus_b.mask;
    ef_b = ~m_lvl[1] & m_lvl_d[1] & ~bus_b.mask;
    chk("a_level", bus_a.level, m_lvl[0]);
    chk("a_rise",  bus_a.rise,  er_a);
    chk("a_fall",  bus_a.fall,  ef_a);
    chk("a_any",   4'(bus_a.any_rise), 4'(|er_a));
    chk("b_level", bus_b.level, m_lvl[1]);
    chk("b_rise",  bus_b.rise,  er_b);
    chk("b_fall",  bus_b.fall,  ef_b);
    chk("b_any",   4'(bus_b.any_rise), 4'(|er_b));
    chk("b_tick",  4'(u_dut_b.w_tick), 4'(m_ph[1] == 2));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Config A: a change applied now must pulse exactly on the 6th edge.
  task automatic expect_pulse(input string tag, input int ch, input bit is_rise);
    logic [3:0] p;
    for (int k = 1; k <= 7; k++) begin
      step();
      p = is_rise ? bus_a.rise : bus_a.fall;
      chk(tag, 4'(p[ch]), 4'(k == 6));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;
    // 1: reset with raw high, outputs 0 without a clock edge
    rstn = 1'b0;
    bus_a.raw = 4'hF; bus_a.mask = 4'h0;
    bus_b.raw = 4'h0; bus_b.mask = 4'h0;
    model_reset();
    #1;
    chk("t1_rst_level", bus_a.level, 4'h0);
    chk("t1_rst_rise",  bus_a.rise,  4'h0);
    chk("t1_rst_fall",  bus_a.fall,  4'h0);
    chk("t1_rst_any",   4'(bus_a.any_rise), 4'h0);
    steps(3);
    rstn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t1_level", bus_a.level, (k >= 6) ? 4'hF : 4'h0);
      chk("t1_rise",  bus_a.rise,  (k == 6) ? 4'hF : 4'h0);
    end

    // 2: single-channel rise then fall
    bus_a.raw = 4'h0;
    steps(8);
    chk("t2_idle_level", bus_a.level, 4'h0);
    bus_a.raw[0] = 1'b1;
    expect_pulse("t2_rise0", 0, 1'b1);
    chk("t2_level0", 4'(bus_a.level[0]), 4'h1);
    bus_a.raw[0] = 1'b0;
    expect_pulse("t2_fall0", 0, 1'b0);
    chk("t2_level0_low", 4'(bus_a.level[0]), 4'h0);

    // 3: bounce trains shorter than STABLE_TICKS are never accepted
    for (int r = 0; r < 4; r++) begin
      bus_a.raw[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin step(); chk("t3_level1", 4'(bus_a.level[1]), 4'h0); end
      bus_a.raw[1] = 1'b0;
      step(); chk("t3_rise1", 4'(bus_a.rise[1]), 4'h0);
    end
    for (int k = 0; k < 6; k++) begin step(); chk("t3_level1_end", 4'(bus_a.level[1]), 4'h0); end

    // 4: masked channel tracks level but emits no pulse
    bus_a.mask = 4'b0100;
    bus_a.raw[2] = 1'b1;
    steps(6);
    chk("t4_level2", 4'(bus_a.level[2]), 4'h1);
    chk("t4_rise2",  4'(bus_a.rise[2]),  4'h0);
    chk("t4_any",    4'(bus_a.any_rise), 4'h0);
    bus_a.raw[3] = 1'b1;
    steps(6);
    chk("t4_rise",   bus_a.rise, 4'b1000);
    chk("t4_any3",   4'(bus_a.any_rise), 4'h1);
    bus_a.raw[3:2] = 2'b00;
    steps(6);
    chk("t4_fall",   bus_a.fall, 4'b1000);
    bus_a.mask = 4'h0;
    steps(2);

    // 6: reset mid-count discards progress
    bus_a.raw[3] = 1'b1;
    steps(8);
    chk("t6_level3", 4'(bus_a.level[3]), 4'h1);
    bus_a.raw[0] = 1'b1;
    steps(4);
    chk("t6_mid_level0", 4'(bus_a.level[0]), 4'h0);
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_level", bus_a.level, 4'h0);
    chk("t6_rst_rise",  bus_a.rise,  4'h0);
    @(negedge clk);
    steps(2);
    rstn = 1'b1;
    expect_pulse("t6_rise0", 0, 1'b1);

    // 5: config B latency bound and single-tick glitch rejection
    bus_b.raw[0] = 1'b1;
    n = 0;
    while (!bus_b.level[0] && n < 20) begin step(); n++; end
    ok = (n >= 1) && (n <= 8);
    chk("t5_latency", 4'(ok), 4'h1);
    bus_b.raw[1] = 1'b1;
    steps(3);
    bus_b.raw[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t5_glitch_level1", 4'(bus_b.level[1]), 4'h0);
      chk("t5_glitch_rise1",  4'(bus_b.rise[1]),  4'h0);
    end

    // Randomized: sparse toggles so some changes are accepted and some bounce
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) bus_a.raw[i] = ~bus_a.raw[i];
        if ($urandom_range(5) == 0) bus_b.raw[i] = ~bus_b.raw[i];
      end
      if ($urandom_range(15) == 0) bus_a.mask = 4'($urandom_range(15));
      if ($urandom_range(15) == 0) bus_b.mask = 4'($urandom_range(15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
